// File: rtl/tcm_pkg.sv
// rtl/tcm_pkg.sv - shared constants and write-state type for the TCM frame buffer
package tcm_pkg;
  localparam int         TCM_DEPTH  = 512;
  localparam int         TCM_ADDR_W = 9;
  localparam logic [7:0] PAD_BYTE   = 8'h00;

  typedef enum logic [1:0] {
    W_IDLE,
    W_FILL,
    W_DROP
  } w_state_t;
endpackage

// File: rtl/tcm_dpram.sv
// rtl/tcm_dpram.sv - simple dual-port byte RAM, one write port, one registered read port
module tcm_dpram #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);
  logic [7:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/tcm_frame_buf.sv
// rtl/tcm_frame_buf.sv - ping-pong frame buffer feeding the UDP return-frame transmitter
module tcm_frame_buf
  import tcm_pkg::*;
#(
  parameter int DEPTH  = TCM_DEPTH,
  parameter int ADDR_W = TCM_ADDR_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  input  logic              in_sof,
  input  logic              in_eof,
  input  logic              in_err,
  input  logic [ADDR_W-1:0] tcm_ra,
  input  logic              tx_done,
  input  logic              clr_stat,
  output logic [7:0]        tcm_wd,
  output logic              tcm_v,
  output logic              tcm_e,
  output logic [ADDR_W:0]   tcm_len,
  output logic              ovf,
  output logic [CNT_W-1:0]  drop_cnt
);
  localparam logic [ADDR_W:0] LEN_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W+1)'(DEPTH);

  w_state_t             state;
  logic                 wbank, rbank;
  logic [ADDR_W:0]      wcnt;
  logic [1:0]           full, err;
  logic [1:0][ADDR_W:0] len;
  logic                 pad_q;
  logic [7:0]           ram_q;

  logic                 sof_v, sof_start, fill_wr, ovf_hit, wr_en, commit, drop_inc, rel;
  logic [ADDR_W-1:0]    wr_addr;

  // A sof may open a frame from idle, restart a partial one, or re-arm out of a drop.
  assign sof_v     = in_valid && in_sof;
  assign sof_start = sof_v && (state == W_FILL ||
                     (!full[wbank] && (state == W_IDLE || (state == W_DROP && !in_eof))));
  assign fill_wr   = in_valid && !in_sof && state == W_FILL && wcnt != LEN_MAX;
  assign ovf_hit   = in_valid && !in_sof && state == W_FILL && wcnt == LEN_MAX;
  assign wr_en     = sof_start || fill_wr;
  assign wr_addr   = sof_start ? '0 : wcnt[ADDR_W-1:0];
  assign commit    = wr_en && in_eof;
  assign drop_inc  = ovf_hit || (sof_v && (state == W_FILL ||
                     (full[wbank] && (state == W_IDLE || (state == W_DROP && !in_eof)))));
  assign rel       = tx_done && tcm_v;

  tcm_dpram #(.AW(ADDR_W + 1)) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr ({wbank, wr_addr}),
    .wdata (in_data),
    .raddr ({rbank, tcm_ra}),
    .rdata (ram_q)
  );

  assign tcm_wd = pad_q ? PAD_BYTE : ram_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= W_IDLE;
      wbank    <= 1'b0;
      rbank    <= 1'b0;
      wcnt     <= '0;
      full     <= '0;
      err      <= '0;
      len      <= '0;
      tcm_v    <= 1'b0;
      tcm_e    <= 1'b0;
      tcm_len  <= '0;
      pad_q    <= 1'b1;
      ovf      <= 1'b0;
      drop_cnt <= '0;
    end else begin
      case (state)
        W_IDLE:  if (sof_v && full[wbank] && !in_eof) state <= W_DROP;
        W_FILL:  if (ovf_hit) state <= W_DROP;
        W_DROP:  if (in_valid && in_eof) state <= W_IDLE;
        default: state <= W_IDLE;
      endcase
      if (sof_start) begin
        state <= W_FILL;
        wcnt  <= LEN_ONE;
      end else if (fill_wr) begin
        wcnt <= wcnt + LEN_ONE;
      end
      if (commit) begin
        state       <= W_IDLE;
        full[wbank] <= 1'b1;
        len[wbank]  <= sof_start ? LEN_ONE : wcnt + LEN_ONE;
        err[wbank]  <= in_err;
        wbank       <= ~wbank;
      end
      // Commit and release always hit different banks: a full bank is never written.
      if (rel) begin
        full[rbank] <= 1'b0;
        rbank       <= ~rbank;
      end
      tcm_v   <= full[rbank] && !rel;
      tcm_e   <= full[rbank] && !rel && err[rbank];
      tcm_len <= (full[rbank] && !rel) ? len[rbank] : '0;
      pad_q   <= !tcm_v || ({1'b0, tcm_ra} >= tcm_len);
      if (clr_stat) begin
        ovf      <= 1'b0;
        drop_cnt <= '0;
      end else begin
        if (ovf_hit) ovf <= 1'b1;
        if (drop_inc && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end
endmodule
